// File: rtl/efpga_tcdm_responder_if.sv
// TCDM request/response bundle between an eFPGA initiator port and its responder.
interface efpga_tcdm_responder_if #(
    parameter int ADDR_W = 20
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              valid;
    logic [31:0]       rdata;
    logic              fmo;
    logic              busy;

    modport master (
        output req, addr, wen, be, wdata,
        input  gnt, valid, rdata, fmo, busy
    );

    modport slave (
        input  req, addr, wen, be, wdata,
        output gnt, valid, rdata, fmo, busy
    );
endinterface

// File: rtl/efpga_tcdm_responder.sv
// Single-bank TCDM responder with programmable grant wait-states and a one-cycle read pipeline.
// Define EFPGA_TCDM_RESP_ERR_EN to flag out-of-range accesses with fmo instead of aliasing them.
module efpga_tcdm_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    efpga_tcdm_responder_if.slave tcdm
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

    logic [3:0]  wcnt_q;
    logic [3:0]  wcnt_d;
    logic        gnt;
    logic        access_ok;
    logic        err_access;
    logic        wr_en;
    logic        rd_en;
    logic        valid_q;
    logic        fmo_q;
    logic [31:0] rdata_q;
    logic [IDX_W-1:0] sel;
    logic [31:0] mem [DEPTH];
    logic        unused_addr;

    assign sel         = tcdm.addr[IDX_W+1:2];
    assign unused_addr = ^tcdm.addr;

`ifdef EFPGA_TCDM_RESP_ERR_EN
    localparam logic [ADDR_W-2:0] DEPTH_CMP = (ADDR_W-1)'(DEPTH);
    logic in_range;

    assign in_range   = ({1'b0, tcdm.addr[ADDR_W-1:2]} < DEPTH_CMP);
    assign access_ok  = in_range;
    assign err_access = ~in_range;
`else
    assign access_ok  = 1'b1;
    assign err_access = 1'b0;
`endif

    assign gnt       = tcdm.req & (wcnt_q == WAIT_LIM);
    assign wr_en     = gnt & ~tcdm.wen & access_ok;
    assign rd_en     = gnt & tcdm.wen & access_ok;

    assign tcdm.gnt   = gnt;
    assign tcdm.busy  = tcdm.req & ~gnt;
    assign tcdm.valid = valid_q;
    assign tcdm.rdata = rdata_q;
    assign tcdm.fmo   = fmo_q;

    // Wait counter restarts whenever the request drops or is granted.
    always_comb begin
        wcnt_d = '0;
        if (tcdm.req && !gnt) begin
            wcnt_d = (wcnt_q == WAIT_LIM) ? wcnt_q : wcnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (tcdm.be[b]) begin
                    mem[sel][8*b +: 8] <= tcdm.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data samples the pre-write word, so a same-edge write is not visible here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            fmo_q   <= 1'b0;
        end else begin
            valid_q <= gnt;
            rdata_q <= rd_en ? mem[sel] : '0;
            fmo_q   <= gnt & err_access;
        end
    end
endmodule

// File: tb/tb_efpga_tcdm_responder.sv
// Self-checking bench: a zero-wait and a three-wait responder against a word-array model.
module tb_efpga_tcdm_responder;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 20;

    logic clk = 1'b0;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m0 [DEPTH];
    logic [31:0] m3 [DEPTH];

    efpga_tcdm_responder_if #(.ADDR_W(ADDR_W)) bus0 ();
    efpga_tcdm_responder_if #(.ADDR_W(ADDR_W)) bus3 ();

    efpga_tcdm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .ADDR_W(ADDR_W)) dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tcdm   (bus0)
    );

    efpga_tcdm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .ADDR_W(ADDR_W)) dut3 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tcdm   (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s: observed %08h expected %08h", tag, what, obs, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < DEPTH; i++) begin
            m0[i] = '0;
            m3[i] = '0;
        end
    endtask

    // One cycle on the zero-wait responder; called at a falling edge, returns at the next one.
    task automatic step0(input string tag, input logic req, input logic [ADDR_W-1:0] addr,
                         input logic wen, input logic [3:0] be, input logic [31:0] wdata);
        int          idx;
        logic        perf;
        logic        efmo;
        logic [31:0] erd;
        bus0.req = req; bus0.addr = addr; bus0.wen = wen; bus0.be = be; bus0.wdata = wdata;
        #1;
        chk(tag, "gnt", 32'(bus0.gnt), 32'(req));
        chk(tag, "busy", 32'(bus0.busy), 32'd0);
        idx  = int'(addr >> 2);
        perf = 1'b1;
        efmo = 1'b0;
`ifdef EFPGA_TCDM_RESP_ERR_EN
        if (idx >= DEPTH) begin
            perf = 1'b0;
            efmo = req;
        end
`endif
        idx = idx % DEPTH;
        erd = '0;
        if (req && perf) begin
            if (wen) erd = m0[idx];
            else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m0[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        @(posedge clk); #1;
        chk(tag, "valid", 32'(bus0.valid), 32'(req));
        chk(tag, "rdata", bus0.rdata, erd);
        chk(tag, "fmo", 32'(bus0.fmo), 32'(efmo));
        @(negedge clk);
    endtask

    // One cycle on the three-wait responder with the grant expectation given by the caller.
    task automatic step3(input string tag, input logic req, input logic [ADDR_W-1:0] addr,
                         input logic wen, input logic [31:0] wdata, input logic exp_gnt);
        int          idx;
        logic [31:0] erd;
        bus3.req = req; bus3.addr = addr; bus3.wen = wen; bus3.be = 4'hF; bus3.wdata = wdata;
        #1;
        chk(tag, "gnt", 32'(bus3.gnt), 32'(exp_gnt));
        chk(tag, "busy", 32'(bus3.busy), 32'(req & ~exp_gnt));
        idx = int'(addr >> 2) % DEPTH;
        erd = '0;
        if (exp_gnt) begin
            if (wen) erd = m3[idx];
            else m3[idx] = wdata;
        end
        @(posedge clk); #1;
        chk(tag, "valid", 32'(bus3.valid), 32'(exp_gnt));
        chk(tag, "rdata", bus3.rdata, erd);
        chk(tag, "fmo", 32'(bus3.fmo), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [ADDR_W-1:0] raddr;
        int                ridx;

        rst_n = 1'b0;
        bus0.req = 1'b0; bus0.addr = '0; bus0.wen = 1'b1; bus0.be = '0; bus0.wdata = '0;
        bus3.req = 1'b0; bus3.addr = '0; bus3.wen = 1'b1; bus3.be = '0; bus3.wdata = '0;
        clear_models();
        @(negedge clk);
        @(negedge clk);
        chk("reset", "gnt", 32'(bus0.gnt), 32'd0);
        chk("reset", "valid", 32'(bus0.valid), 32'd0);
        chk("reset", "rdata", bus0.rdata, 32'd0);
        chk("reset", "fmo", 32'(bus0.fmo), 32'd0);
        chk("reset", "busy", 32'(bus0.busy), 32'd0);
        chk("reset", "valid3", 32'(bus3.valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write/read, byte enables and an empty byte mask
        step0("wr_basic", 1'b1, 20'h00010, 1'b0, 4'hF, 32'hDEADBEEF);
        step0("rd_basic", 1'b1, 20'h00010, 1'b1, 4'h0, 32'h0);
        step0("idle0", 1'b0, 20'h0, 1'b1, 4'h0, 32'h0);
        step0("wr_be", 1'b1, 20'h00010, 1'b0, 4'b0101, 32'h11223344);
        step0("rd_be", 1'b1, 20'h00012, 1'b1, 4'h0, 32'h0);
        chk("be_word", "model", m0[4], 32'hDE22BE44);
        step0("wr_be0", 1'b1, 20'h00010, 1'b0, 4'h0, 32'hFFFFFFFF);
        step0("rd_be0", 1'b1, 20'h00010, 1'b1, 4'h0, 32'h0);

        // Pipelined stream: writes, then eight back-to-back reads
        for (int i = 0; i < 8; i++)
            step0("stream_wr", 1'b1, 20'(i * 4), 1'b0, 4'hF, 32'(i + 1) * 32'h01010101);
        for (int i = 0; i < 8; i++)
            step0("stream_rd", 1'b1, 20'(i * 4), 1'b1, 4'h0, 32'h0);
        step0("idle1", 1'b0, 20'h0, 1'b1, 4'h0, 32'h0);

        // Out-of-range access at word index DEPTH
        step0("oor_wr", 1'b1, 20'h00400, 1'b0, 4'hF, 32'hA5A5A5A5);
        step0("oor_rd", 1'b1, 20'h00400, 1'b1, 4'h0, 32'h0);
        step0("oor_w0", 1'b1, 20'h00000, 1'b1, 4'h0, 32'h0);
        step0("idle2", 1'b0, 20'h0, 1'b1, 4'h0, 32'h0);

        // Three-wait responder: held request, back-to-back waits, abandoned request
        for (int k = 0; k < 4; k++)
            step3("w3_wr", 1'b1, 20'h00020, 1'b0, 32'h12345678, k == 3);
        for (int k = 0; k < 4; k++)
            step3("w3_rd", 1'b1, 20'h00020, 1'b1, 32'h0, k == 3);
        step3("w3_idle", 1'b0, 20'h0, 1'b1, 32'h0, 1'b0);
        step3("w3_drop", 1'b1, 20'h00020, 1'b1, 32'h0, 1'b0);
        step3("w3_drop", 1'b1, 20'h00020, 1'b1, 32'h0, 1'b0);
        step3("w3_idle", 1'b0, 20'h0, 1'b1, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++)
            step3("w3_rerd", 1'b1, 20'h00020, 1'b1, 32'h0, k == 3);
        step3("w3_idle", 1'b0, 20'h0, 1'b1, 32'h0, 1'b0);

        // Reset pulse between grant and response
        bus0.req = 1'b1; bus0.addr = 20'h00010; bus0.wen = 1'b0; bus0.be = 4'hF; bus0.wdata = 32'hCAFEF00D;
        #1;
        chk("rst_mid", "gnt", 32'(bus0.gnt), 32'd1);
        #1;
        rst_n = 1'b0;
        bus0.req = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid", "valid", 32'(bus0.valid), 32'd0);
        chk("rst_mid", "rdata", bus0.rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_models();
        @(negedge clk);
        step0("post_rst", 1'b1, 20'h00010, 1'b1, 4'h0, 32'h0);
        step0("post_rst", 1'b1, 20'h00004, 1'b1, 4'h0, 32'h0);
        step3("post_rst3", 1'b1, 20'h00020, 1'b1, 32'h0, 1'b0);
        for (int k = 1; k < 4; k++)
            step3("post_rst3", 1'b1, 20'h00020, 1'b1, 32'h0, k == 3);
        step3("w3_idle", 1'b0, 20'h0, 1'b1, 32'h0, 1'b0);

        // Randomized traffic on the zero-wait responder
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) ridx = int'($urandom_range(DEPTH, (1 << (ADDR_W - 2)) - 1));
            else ridx = int'($urandom_range(0, 63));
            raddr = ADDR_W'(ridx * 4 + int'($urandom_range(0, 3)));
            step0("random", $urandom_range(0, 3) != 0, raddr, 1'($urandom), 4'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
